// File: rtl/img_pkg.sv
// Shared image geometry, line-buffer count and controller state encoding.
package img_pkg;

    localparam int unsigned IMG_W_DEF = 512;
    localparam int unsigned PIX_W_DEF = 8;
    localparam int unsigned NUM_LB    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } lb_state_e;

    // One-hot select of one of the four line buffers.
    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/linebuffer_top.sv
// Controller plus its four line buffers; shared rst clears all pointers together.
module linebuffer_top #(
    parameter int unsigned IMG_W = img_pkg::IMG_W_DEF,
    parameter int unsigned PIX_W = img_pkg::PIX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_in_valid,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               win_ready,
    output logic [9*PIX_W-1:0] win_data,
    output logic               win_valid,
    output logic               line_freed
);
    import img_pkg::*;

    logic [3:0]         wr_en;
    logic [3:0]         rd_en;
    logic [PIX_W-1:0]   wr_data;
    logic [3*PIX_W-1:0] dout [NUM_LB];

    for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
        pixelbuffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_pb (
            .clk          (clk),
            .rst          (rst),
            .valid_pixel_i(wr_en[i]),
            .pixel_i      (wr_data),
            .read_pixel_i (rd_en[i]),
            .pixel_o      (dout[i])
        );
    end

    linebuffer_ctrl #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .pix_in_valid(pix_in_valid),
        .pix_in      (pix_in),
        .lb_wr_en    (wr_en),
        .lb_wr_data  (wr_data),
        .lb_rd_en    (rd_en),
        .lb_dout0    (dout[0]),
        .lb_dout1    (dout[1]),
        .lb_dout2    (dout[2]),
        .lb_dout3    (dout[3]),
        .win_ready   (win_ready),
        .win_data    (win_data),
        .win_valid   (win_valid),
        .line_freed  (line_freed)
    );

endmodule

// File: rtl/pixelbuffer.sv
// One image line of pixel storage; presents three horizontally adjacent pixels
// starting at the read pointer, oldest pixel in the MSBs.
module pixelbuffer #(
    parameter int unsigned IMG_W = img_pkg::IMG_W_DEF,
    parameter int unsigned PIX_W = img_pkg::PIX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_pixel_i,
    input  logic [PIX_W-1:0]   pixel_i,
    input  logic               read_pixel_i,
    output logic [3*PIX_W-1:0] pixel_o
);
    localparam int unsigned CNT_W = $clog2(IMG_W);
    localparam logic [CNT_W-1:0] PTR_LAST = CNT_W'(IMG_W - 1);

    logic [PIX_W-1:0] mem_q [IMG_W];
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] rd_p1, rd_p2;

    always_ff @(posedge clk) begin
        if (valid_pixel_i) mem_q[wr_ptr_q] <= pixel_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (valid_pixel_i) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + CNT_W'(1);
        if (read_pixel_i)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Window neighbours wrap around the line end.
    assign rd_p1   = CNT_W'((32'(rd_ptr_q) + 32'd1) % IMG_W);
    assign rd_p2   = CNT_W'((32'(rd_ptr_q) + 32'd2) % IMG_W);
    assign pixel_o = {mem_q[rd_ptr_q], mem_q[rd_p1], mem_q[rd_p2]};

endmodule

// File: rtl/linebuffer_ctrl.sv
// Rotating four-line-buffer controller: steers raster pixels into buffers and
// reads three completed lines as a 3x3 window stream.
module linebuffer_ctrl #(
    parameter int unsigned IMG_W = img_pkg::IMG_W_DEF,
    parameter int unsigned PIX_W = img_pkg::PIX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_in_valid,
    input  logic [PIX_W-1:0]   pix_in,
    output logic [3:0]         lb_wr_en,
    output logic [PIX_W-1:0]   lb_wr_data,
    output logic [3:0]         lb_rd_en,
    input  logic [3*PIX_W-1:0] lb_dout0,
    input  logic [3*PIX_W-1:0] lb_dout1,
    input  logic [3*PIX_W-1:0] lb_dout2,
    input  logic [3*PIX_W-1:0] lb_dout3,
    input  logic               win_ready,
    output logic [9*PIX_W-1:0] win_data,
    output logic               win_valid,
    output logic               line_freed
);
    import img_pkg::*;

    localparam int unsigned CNT_W  = $clog2(IMG_W);
    localparam int unsigned FILL_W = $clog2(NUM_LB * IMG_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(IMG_W - 1);
    localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(NUM_LB * IMG_W);
    localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * IMG_W);

    lb_state_e         state_q, state_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [1:0]        wr_sel_q, wr_sel_d;
    logic [1:0]        rd_sel_q, rd_sel_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic              line_freed_q, line_freed_d;
    logic              wr_fire, rd_fire;
    logic [1:0]        rd_sel1, rd_sel2;
    logic [3*PIX_W-1:0] dout [NUM_LB];

    assign dout[0] = lb_dout0;
    assign dout[1] = lb_dout1;
    assign dout[2] = lb_dout2;
    assign dout[3] = lb_dout3;

    assign wr_fire = pix_in_valid & ~rst;
    assign rd_fire = (state_q == ST_READ) & win_ready & ~rst;
    assign rd_sel1 = rd_sel_q + 2'd1;
    assign rd_sel2 = rd_sel_q + 2'd2;

    // Write steering and occupancy; overrun writes are passed through, count saturates.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        wr_sel_d   = wr_sel_q;
        fill_cnt_d = fill_cnt_q;
        if (wr_fire) begin
            if (wr_cnt_q == CNT_LAST) begin
                wr_cnt_d = '0;
                wr_sel_d = wr_sel_q + 2'd1;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end
        if (wr_fire && !rd_fire && fill_cnt_q != FILL_MAX) begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
        end else if (!wr_fire && rd_fire && fill_cnt_q != '0) begin
            fill_cnt_d = fill_cnt_q - FILL_W'(1);
        end
    end

    // Read FSM; entry looks at the updated occupancy so the window follows the last write directly.
    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        rd_sel_d     = rd_sel_q;
        line_freed_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rst && fill_cnt_d >= FILL_START) state_d = ST_READ;
            end
            ST_READ: begin
                if (rd_fire) begin
                    if (rd_cnt_q == CNT_LAST) begin
                        rd_cnt_d     = '0;
                        rd_sel_d     = rd_sel_q + 2'd1;
                        line_freed_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            wr_sel_q     <= '0;
            rd_sel_q     <= '0;
            fill_cnt_q   <= '0;
            line_freed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            fill_cnt_q   <= fill_cnt_d;
            line_freed_q <= line_freed_d;
        end
    end

    assign lb_wr_data = pix_in;
    assign lb_wr_en   = wr_fire ? onehot4(wr_sel_q) : 4'b0000;
    assign lb_rd_en   = rd_fire ? (onehot4(rd_sel_q) | onehot4(rd_sel1) | onehot4(rd_sel2)) : 4'b0000;
    assign win_valid  = rd_fire;
    assign win_data   = {dout[rd_sel_q], dout[rd_sel1], dout[rd_sel2]};
    assign line_freed = line_freed_q;

endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Directed bench: bare controller with fixed buffer outputs, plus the full
// wrapper fed the same stimulus and checked against a ramp-image window model.
module tb_linebuffer_ctrl;
    import img_pkg::*;

    localparam int W = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_in_valid;
    logic [7:0]  pix_in;
    logic        win_ready;
    logic [3:0]  lb_wr_en, lb_rd_en;
    logic [7:0]  lb_wr_data;
    logic [23:0] lb_dout0, lb_dout1, lb_dout2, lb_dout3;
    logic [71:0] win_data, t_win_data;
    logic        win_valid, line_freed, t_win_valid, t_line_freed;

    logic [23:0] dconst [4] = '{24'h010203, 24'h111213, 24'h212223, 24'h313233};
    int bufline [4];
    int errors = 0;
    int checks = 0;

    assign lb_dout0 = dconst[0];
    assign lb_dout1 = dconst[1];
    assign lb_dout2 = dconst[2];
    assign lb_dout3 = dconst[3];

    always #5 clk = ~clk;

    linebuffer_ctrl dut (
        .clk(clk), .rst(rst), .pix_in_valid(pix_in_valid), .pix_in(pix_in),
        .lb_wr_en(lb_wr_en), .lb_wr_data(lb_wr_data), .lb_rd_en(lb_rd_en),
        .lb_dout0(lb_dout0), .lb_dout1(lb_dout1), .lb_dout2(lb_dout2), .lb_dout3(lb_dout3),
        .win_ready(win_ready), .win_data(win_data), .win_valid(win_valid), .line_freed(line_freed)
    );

    linebuffer_top u_top (
        .clk(clk), .rst(rst), .pix_in_valid(pix_in_valid), .pix_in(pix_in),
        .win_ready(win_ready), .win_data(t_win_data), .win_valid(t_win_valid),
        .line_freed(t_line_freed)
    );

    function automatic logic [7:0] pixv(int line, int col);
        return 8'(col * 3 + line * 29);
    endfunction

    function automatic logic [71:0] gold_win(int s, int k);
        logic [71:0] w;
        int ln;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            ln = bufline[(s + r) % 4];
            w[71 - 24 * r -: 24] = {pixv(ln, k), pixv(ln, (k + 1) % W), pixv(ln, (k + 2) % W)};
        end
        return w;
    endfunction

    function automatic logic [71:0] sel_win(int s);
        return {dconst[s % 4], dconst[(s + 1) % 4], dconst[(s + 2) % 4]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_in_valid = 1'b1; pix_in = 8'hFF; win_ready = 1'b1;
        tick();
        #2;
        checks++;
        if (lb_wr_en !== 4'b0000 || lb_rd_en !== 4'b0000 || win_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs wr_en=%b rd_en=%b win_valid=%b exp 0000/0000/0", lb_wr_en, lb_rd_en, win_valid);
        end
        tick();
        rst = 1'b0; pix_in_valid = 1'b0; win_ready = 1'b0;
        #2;
        checks++;
        if (line_freed !== 1'b0 || dut.state_q !== ST_IDLE || dut.fill_cnt_q !== 12'd0) begin
            errors++;
            $display("FAIL reset_state line_freed=%b state=%0d fill=%0d exp 0/IDLE/0", line_freed, dut.state_q, dut.fill_cnt_q);
        end
        tick();
    endtask

    task automatic test_fill();
        win_ready = 1'b1;
        for (int c = 0; c < 3 * W; c++) begin
            pix_in_valid = 1'b1; pix_in = pixv(c / W, c % W);
            #2;
            if (c % W == 0) begin
                checks++;
                if (lb_wr_en !== 4'(1 << (c / W))) begin
                    errors++;
                    $display("FAIL fill_wr_en line=%0d got %b exp %b", c / W, lb_wr_en, 4'(1 << (c / W)));
                end
            end
            if (c == 3 * W - 1) begin
                checks++;
                if (win_valid !== 1'b0 || lb_wr_data !== pix_in) begin
                    errors++;
                    $display("FAIL fill_last_write win_valid=%b wr_data=%h exp 0/%h", win_valid, lb_wr_data, pix_in);
                end
            end
            tick();
        end
        for (int b = 0; b < 3; b++) bufline[b] = b;
        pix_in_valid = 1'b0;
        #2;
        checks++;
        if (win_valid !== 1'b1 || lb_rd_en !== 4'b0111) begin
            errors++;
            $display("FAIL first_window win_valid=%b rd_en=%b exp 1/0111", win_valid, lb_rd_en);
        end
        checks++;
        if (t_win_data !== gold_win(0, 0) || win_data !== sel_win(0)) begin
            errors++;
            $display("FAIL first_window_data top=%h exp %h ctrl=%h exp %h", t_win_data, gold_win(0, 0), win_data, sel_win(0));
        end
        tick();
    endtask

    task automatic test_read_line();
        int k = 1;
        int cyc = 0;
        win_ready = 1'b1; pix_in_valid = 1'b0;
        while (k < W && cyc < 4 * W) begin
            #2;
            if (t_win_valid === 1'b1) begin
                checks++;
                if (t_win_data !== gold_win(0, k)) begin
                    errors++;
                    $display("FAIL line0_win k=%0d got %h exp %h", k, t_win_data, gold_win(0, k));
                end
                k++;
            end
            tick(); cyc++;
        end
        #2;
        checks++;
        if (k != W || line_freed !== 1'b1 || t_line_freed !== 1'b1 || win_valid !== 1'b0) begin
            errors++;
            $display("FAIL line0_end windows=%0d freed=%b/%b win_valid=%b exp %0d/1/1/0", k, line_freed, t_line_freed, win_valid, W);
        end
        tick();
        #2;
        checks++;
        if (line_freed !== 1'b0 || lb_rd_en !== 4'b0000) begin
            errors++;
            $display("FAIL line0_freed_pulse freed=%b rd_en=%b exp 0/0000", line_freed, lb_rd_en);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        int k = 100;
        int cyc = 0;
        win_ready = 1'b0;
        for (int c = 0; c < W; c++) begin
            pix_in_valid = 1'b1; pix_in = pixv(3, c);
            #2;
            if (c == 0) begin
                checks++;
                if (lb_wr_en !== 4'b1000) begin
                    errors++;
                    $display("FAIL line3_wr_en got %b exp 1000", lb_wr_en);
                end
            end
            tick();
        end
        bufline[3] = 3;
        bufline[0] = 4;
        win_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            pix_in_valid = 1'b1; pix_in = pixv(4, c);
            #2;
            if (c == 0) begin
                checks++;
                if (lb_wr_en !== 4'b0001 || lb_rd_en !== 4'b1110 || win_data !== sel_win(1)) begin
                    errors++;
                    $display("FAIL sim_start wr_en=%b rd_en=%b ctrl_win=%h exp 0001/1110/%h", lb_wr_en, lb_rd_en, win_data, sel_win(1));
                end
            end
            checks++;
            if (t_win_valid !== 1'b1 || t_win_data !== gold_win(1, c)) begin
                errors++;
                $display("FAIL sim_win k=%0d valid=%b got %h exp %h", c, t_win_valid, t_win_data, gold_win(1, c));
            end
            tick();
        end
        #2;
        checks++;
        if (dut.fill_cnt_q !== 12'd1536) begin
            errors++;
            $display("FAIL sim_fill got %0d exp 1536", dut.fill_cnt_q);
        end
        pix_in_valid = 1'b0;
        while (k < W && cyc < 4 * W) begin
            #2;
            if (t_win_valid === 1'b1) begin
                checks++;
                if (t_win_data !== gold_win(1, k)) begin
                    errors++;
                    $display("FAIL line1_win k=%0d got %h exp %h", k, t_win_data, gold_win(1, k));
                end
                k++;
            end
            tick(); cyc++;
        end
        #2;
        checks++;
        if (k != W || line_freed !== 1'b1) begin
            errors++;
            $display("FAIL line1_end windows=%0d freed=%b exp %0d/1", k, line_freed, W);
        end
        win_ready = 1'b0;
        for (int c = 100; c < W; c++) begin
            pix_in_valid = 1'b1; pix_in = pixv(4, c);
            tick();
        end
        pix_in_valid = 1'b0;
    endtask

    task automatic test_gated();
        int k = 0;
        int cyc = 0;
        pix_in_valid = 1'b0;
        while (k < W && cyc < 4 * W) begin
            win_ready = (cyc % 2 == 0);
            #2;
            if (!win_ready) begin
                checks++;
                if (t_win_valid !== 1'b0 || lb_rd_en !== 4'b0000) begin
                    errors++;
                    $display("FAIL gated_stall cyc=%0d valid=%b rd_en=%b exp 0/0000", cyc, t_win_valid, lb_rd_en);
                end
            end else if (t_win_valid === 1'b1) begin
                checks++;
                if (t_win_data !== gold_win(2, k)) begin
                    errors++;
                    $display("FAIL gated_win k=%0d got %h exp %h", k, t_win_data, gold_win(2, k));
                end
                k++;
            end
            tick(); cyc++;
        end
        win_ready = 1'b1;
        #2;
        checks++;
        if (k != W || line_freed !== 1'b1 || win_valid !== 1'b0) begin
            errors++;
            $display("FAIL gated_end windows=%0d freed=%b win_valid=%b exp %0d/1/0", k, line_freed, win_valid, W);
        end
        tick();
    endtask

    task automatic test_wrap();
        int k = 0;
        int cyc = 0;
        win_ready = 1'b1;
        for (int c = 0; c < W; c++) begin
            pix_in_valid = 1'b1; pix_in = pixv(5, c);
            #2;
            if (c == 0 || c == W - 1) begin
                checks++;
                if (lb_wr_en !== 4'b0010 || win_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL line5_write c=%0d wr_en=%b win_valid=%b exp 0010/0", c, lb_wr_en, win_valid);
                end
            end
            tick();
        end
        bufline[1] = 5;
        pix_in_valid = 1'b0;
        #2;
        checks++;
        if (lb_rd_en !== 4'b1011 || win_data !== sel_win(3)) begin
            errors++;
            $display("FAIL wrap_rd_en got %b ctrl_win %h exp 1011 %h", lb_rd_en, win_data, sel_win(3));
        end
        while (k < W && cyc < 4 * W) begin
            #2;
            if (t_win_valid === 1'b1) begin
                checks++;
                if (t_win_data !== gold_win(3, k)) begin
                    errors++;
                    $display("FAIL wrap_win k=%0d got %h exp %h", k, t_win_data, gold_win(3, k));
                end
                k++;
            end
            tick(); cyc++;
        end
        #2;
        checks++;
        if (k != W || line_freed !== 1'b1 || dut.rd_sel_q !== 2'd0 || dut.wr_sel_q !== 2'd2) begin
            errors++;
            $display("FAIL wrap_end windows=%0d freed=%b rd_sel=%0d wr_sel=%0d exp %0d/1/0/2", k, line_freed, dut.rd_sel_q, dut.wr_sel_q, W);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        win_ready = 1'b0;
        for (int c = 0; c < W; c++) begin
            pix_in_valid = 1'b1; pix_in = pixv(6, c);
            #2;
            if (c == 0) begin
                checks++;
                if (lb_wr_en !== 4'b0100) begin
                    errors++;
                    $display("FAIL line6_wr_en got %b exp 0100", lb_wr_en);
                end
            end
            tick();
        end
        bufline[2] = 6;
        pix_in_valid = 1'b0; win_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            #2;
            checks++;
            if (t_win_valid !== 1'b1 || t_win_data !== gold_win(0, k)) begin
                errors++;
                $display("FAIL line4_win k=%0d valid=%b got %h exp %h", k, t_win_valid, t_win_data, gold_win(0, k));
            end
            tick();
        end
        rst = 1'b1; pix_in_valid = 1'b1; pix_in = 8'h33;
        #2;
        checks++;
        if (dut.rd_cnt_q !== 9'd200 || lb_wr_en !== 4'b0000 || lb_rd_en !== 4'b0000 || win_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_cycle rd_cnt=%0d wr_en=%b rd_en=%b win_valid=%b exp 200/0000/0000/0", dut.rd_cnt_q, lb_wr_en, lb_rd_en, win_valid);
        end
        tick();
        rst = 1'b0; pix_in_valid = 1'b0;
        #2;
        checks++;
        if (win_valid !== 1'b0 || lb_rd_en !== 4'b0000 || lb_wr_en !== 4'b0000 || line_freed !== 1'b0 ||
            dut.state_q !== ST_IDLE || dut.fill_cnt_q !== 12'd0) begin
            errors++;
            $display("FAIL after_mid_reset win_valid=%b rd_en=%b wr_en=%b freed=%b state=%0d fill=%0d exp all 0 IDLE",
                     win_valid, lb_rd_en, lb_wr_en, line_freed, dut.state_q, dut.fill_cnt_q);
        end
        tick();
        pix_in_valid = 1'b1; pix_in = 8'h5A;
        #2;
        checks++;
        if (lb_wr_en !== 4'b0001 || lb_wr_data !== 8'h5A) begin
            errors++;
            $display("FAIL post_reset_pixel wr_en=%b data=%h exp 0001/5a", lb_wr_en, lb_wr_data);
        end
        tick();
        pix_in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; pix_in_valid = 1'b0; pix_in = '0; win_ready = 1'b0;
        for (int b = 0; b < 4; b++) bufline[b] = -1;
        test_reset();
        test_fill();
        test_read_line();
        test_simultaneous();
        test_gated();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
